adrv9001_rx_axis_packer: RTL and testbench

//  Downstream of the RX serdes aligner. Packs each aligned 16-bit I/Q sample pair

---
 rtl/adrv9001_rx_axis_packer.sv | 154 +++++++++++++++
 tb/tb_adrv9001_rx_axis_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_rx_axis_packer.sv
// adrv9001_rx_axis_packer
// Packs aligned 16-bit I/Q sample pairs into 32-bit AXI4-Stream beats.
// Beats go through a first-word-fall-through FIFO. tlast is set on every
// FRAME_LEN-th sample. A sticky flag records samples dropped while the FIFO is full.

module adrv9001_rx_axis_packer #(
    parameter int FIFO_DEPTH = 16,   // power of 2, >= 4
    parameter int FRAME_LEN  = 1024, // samples per frame, 1..65536
    parameter int SWAP_IQ    = 0     // 0: {q,i}  1: {i,q}
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic [15:0]                   i_in,
    input  logic [15:0]                   q_in,
    input  logic                          valid_in,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [32:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic [AW:0]    r_fill;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_next;
    logic           r_overflow;

    logic           w_empty;
    logic           w_full;
    logic           w_write_req;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    logic           w_last;
    logic [31:0]    w_pair;
    logic [32:0]    w_head;

    // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Full is sampled before the same-cycle pop, so a pop never rescues a write at full.
    assign w_write_req = valid_in && (r_state != S_IDLE);
    assign w_push      = w_write_req && !w_full;
    assign w_drop      = w_write_req && w_full;
    assign w_pop       = !w_empty && m_axis_tready;
    assign w_last      = (r_cnt == CNT_LAST);

    assign w_pair      = (SWAP_IQ != 0) ? {i_in, q_in} : {q_in, i_in};

    // Sample counter value after this cycle's write (if any)
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
        w_cnt_next = r_cnt;
        if (w_push) begin
            w_cnt_next = w_last ? '0 : r_cnt + CW'(1);
        end
    end

    // Write-side FSM next state; the decisions use the post-write count so a frame is never cut short
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (!enable) w_state_next = (w_cnt_next != '0) ? S_FINISH : S_IDLE;
            end
            S_FINISH: begin
                if (enable)                w_state_next = S_RUN;
                else if (w_push && w_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register and frame sample counter
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // FIFO storage for {last, data}
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the outputs are gated by tvalid, so stale entries are never visible.
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_last, w_pair};
        end
    end

    // FIFO pointers and registered occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (AW+1)'(1);
                2'b01:   r_fill <= r_fill - (AW+1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // The FWFT head is read straight from storage; tvalid comes only from registered pointers
    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = m_axis_tvalid ? w_head[31:0] : 32'd0;
    assign m_axis_tlast  = m_axis_tvalid ? w_head[32]   : 1'b0;
    assign overflow      = r_overflow;
    assign fill_level    = r_fill;

endmodule

// File: tb/tb_adrv9001_rx_axis_packer.sv
// Testbench for adrv9001_rx_axis_packer.
// Instance A: FIFO_DEPTH=4, FRAME_LEN=4, {q,i} packing.
// Instance B: FIFO_DEPTH=8, FRAME_LEN=1, {i,q} packing.
// Both instances share the sample-side inputs. Each instance has its own tready.

module tb_adrv9001_rx_axis_packer;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b1;
    logic        enable   = 1'b0;
    logic        valid_in = 1'b0;
    logic [15:0] i_in     = '0;
    logic [15:0] q_in     = '0;
    logic        ovf_clr  = 1'b0;
    logic        a_tready = 1'b0;
    logic        b_tready = 1'b1;

    logic [31:0] a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid, a_tlast, b_tlast, a_ovf, b_ovf;
    logic [2:0]  a_fill;
    logic [3:0]  b_fill;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adrv9001_rx_axis_packer #(.FIFO_DEPTH(4), .FRAME_LEN(4), .SWAP_IQ(0)) dut_a (
        .clk(clk), .rstn(rstn), .enable(enable), .i_in(i_in), .q_in(q_in),
        .valid_in(valid_in), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
        .m_axis_tready(a_tready), .m_axis_tlast(a_tlast), .overflow(a_ovf),
        .overflow_clr(ovf_clr), .fill_level(a_fill)
    );

    adrv9001_rx_axis_packer #(.FIFO_DEPTH(8), .FRAME_LEN(1), .SWAP_IQ(1)) dut_b (
        .clk(clk), .rstn(rstn), .enable(enable), .i_in(i_in), .q_in(q_in),
        .valid_in(valid_in), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(b_tready), .m_axis_tlast(b_tlast), .overflow(b_ovf),
        .overflow_clr(ovf_clr), .fill_level(b_fill)
    );

    typedef struct {
        logic        en;
        logic        vld;
        logic [15:0] i;
        logic [15:0] q;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic [2:0]  e_fill;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic en, input logic vld,
                                input logic [15:0] i, input logic [15:0] q,
                                input logic rdy, input logic clr,
                                input logic e_valid, input logic [31:0] e_data,
                                input logic e_last, input logic [2:0] e_fill,
                                input logic e_ovf);
        vec_t v;
        v.en = en; v.vld = vld; v.i = i; v.q = q; v.rdy = rdy; v.clr = clr;
        v.e_valid = e_valid; v.e_data = e_data; v.e_last = e_last;
        v.e_fill = e_fill; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of sample-side inputs; return 1 time unit after the edge
    task automatic cyc(input logic en, input logic vld, input logic [15:0] i, input logic [15:0] q);
        enable   = en;
        valid_in = vld;
        i_in     = i;
        q_in     = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q [$];
        logic        stall_prev;
        logic [31:0] prev_data;

        // Table: en vld i q rdy clr | tvalid tdata tlast fill ovf  (instance A)
        // Streaming with tready=1, FRAME_LEN=4: tlast on samples 3 and 7
        vecs[0]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 32'h0000_0000, 0, 3'd0, 0);
        vecs[1]  = mk(1, 1, 16'h0000, 16'h0100, 1, 0, 1, 32'h0100_0000, 0, 3'd1, 0);
        vecs[2]  = mk(1, 1, 16'h0001, 16'h0101, 1, 0, 1, 32'h0101_0001, 0, 3'd1, 0);
        vecs[3]  = mk(1, 1, 16'h0002, 16'h0102, 1, 0, 1, 32'h0102_0002, 0, 3'd1, 0);
        vecs[4]  = mk(1, 1, 16'h0003, 16'h0103, 1, 0, 1, 32'h0103_0003, 1, 3'd1, 0);
        vecs[5]  = mk(1, 1, 16'h0004, 16'h0104, 1, 0, 1, 32'h0104_0004, 0, 3'd1, 0);
        vecs[6]  = mk(1, 1, 16'h0005, 16'h0105, 1, 0, 1, 32'h0105_0005, 0, 3'd1, 0);
        vecs[7]  = mk(1, 1, 16'h0006, 16'h0106, 1, 0, 1, 32'h0106_0006, 0, 3'd1, 0);
        vecs[8]  = mk(1, 1, 16'h0007, 16'h0107, 1, 0, 1, 32'h0107_0007, 1, 3'd1, 0);
        vecs[9]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 32'h0000_0000, 0, 3'd0, 0);
        // Stalled consumer: fill to 4, then two drops; the second drop has clear asserted too
        vecs[10] = mk(1, 1, 16'h0010, 16'h0020, 0, 0, 1, 32'h0020_0010, 0, 3'd1, 0);
        vecs[11] = mk(1, 1, 16'h0011, 16'h0021, 0, 0, 1, 32'h0020_0010, 0, 3'd2, 0);
        vecs[12] = mk(1, 1, 16'h0012, 16'h0022, 0, 0, 1, 32'h0020_0010, 0, 3'd3, 0);
        vecs[13] = mk(1, 1, 16'h0013, 16'h0023, 0, 0, 1, 32'h0020_0010, 0, 3'd4, 0);
        vecs[14] = mk(1, 1, 16'h0014, 16'h0024, 0, 0, 1, 32'h0020_0010, 0, 3'd4, 1);
        vecs[15] = mk(1, 1, 16'h0015, 16'h0025, 0, 1, 1, 32'h0020_0010, 0, 3'd4, 1);
        vecs[16] = mk(1, 0, 16'h0000, 16'h0000, 0, 1, 1, 32'h0020_0010, 0, 3'd4, 0);
        // Pop at full does not let the same-cycle write in
        vecs[17] = mk(1, 1, 16'h0016, 16'h0026, 1, 0, 1, 32'h0021_0011, 0, 3'd3, 1);
        vecs[18] = mk(1, 0, 16'h0000, 16'h0000, 1, 1, 1, 32'h0022_0012, 0, 3'd2, 0);
        vecs[19] = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 1, 32'h0023_0013, 1, 3'd1, 0);
        vecs[20] = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 32'h0000_0000, 0, 3'd0, 0);

        // Reset state
        #1 rstn = 1'b0;
        #1;
        check("rst_tvalid", a_tvalid, 0);
        check("rst_tdata",  a_tdata,  0);
        check("rst_tlast",  a_tlast,  0);
        check("rst_fill",   a_fill,   0);
        check("rst_ovf",    a_ovf,    0);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Table-driven vectors
        for (int k = 0; k < NV; k++) begin
            a_tready = vecs[k].rdy;
            ovf_clr  = vecs[k].clr;
            cyc(vecs[k].en, vecs[k].vld, vecs[k].i, vecs[k].q);
            check($sformatf("v%0d_tvalid", k), a_tvalid, vecs[k].e_valid);
            check($sformatf("v%0d_tdata", k),  a_tdata,  vecs[k].e_data);
            check($sformatf("v%0d_tlast", k),  a_tlast,  vecs[k].e_last);
            check($sformatf("v%0d_fill", k),   a_fill,   vecs[k].e_fill);
            check($sformatf("v%0d_ovf", k),    a_ovf,    vecs[k].e_ovf);
        end
        ovf_clr = 1'b0;

        // Enable drops mid-frame: the frame still completes, then writes stop
        a_tready = 1'b1;
        cyc(1, 1, 16'h0030, 16'h0060);
        check("t3_beat0", a_tdata, 32'h0060_0030);
        cyc(1, 1, 16'h0031, 16'h0061);
        check("t3_beat1", a_tdata, 32'h0061_0031);
        cyc(0, 0, 16'h0000, 16'h0000);
        check("t3_gap_tvalid", a_tvalid, 0);
        cyc(0, 1, 16'h0032, 16'h0062);
        check("t3_beat2", a_tdata, 32'h0062_0032);
        check("t3_beat2_last", a_tlast, 0);
        cyc(0, 1, 16'h0033, 16'h0063);
        check("t3_beat3", a_tdata, 32'h0063_0033);
        check("t3_beat3_last", a_tlast, 1);
        cyc(0, 1, 16'h0034, 16'h0064);
        check("t3_idle_tvalid", a_tvalid, 0);
        check("t3_idle_fill", a_fill, 0);
        cyc(0, 1, 16'h0035, 16'h0065);
        check("t3_idle_tvalid2", a_tvalid, 0);
        check("t3_ovf", a_ovf, 0);

        // Asynchronous reset mid-frame with 3 beats buffered
        a_tready = 1'b0;
        cyc(1, 0, 16'h0000, 16'h0000);
        cyc(1, 1, 16'h0040, 16'h0080);
        cyc(1, 1, 16'h0041, 16'h0081);
        cyc(1, 1, 16'h0042, 16'h0082);
        check("t4_fill3", a_fill, 3);
        check("t4_head", a_tdata, 32'h0080_0040);
        #2 rstn = 1'b0;
        #1;
        check("t4_rst_tvalid", a_tvalid, 0);
        check("t4_rst_fill", a_fill, 0);
        check("t4_rst_tdata", a_tdata, 0);
        @(negedge clk);
        rstn     = 1'b1;
        a_tready = 1'b1;
        cyc(1, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 16'h0050 + 16'(k), 16'h0090 + 16'(k));
            check($sformatf("t4_frame_data%0d", k), a_tdata, 32'h0090_0050 + 32'(k) * 32'h0001_0001);
            check($sformatf("t4_frame_last%0d", k), a_tlast, (k == 3));
        end

        // Instance B: swapped packing, FRAME_LEN=1, tready toggling
        cyc(1, 0, 16'h0000, 16'h0000);
        cyc(1, 0, 16'h0000, 16'h0000);
        cyc(1, 1, 16'h1234, 16'hABCD);
        check("t5_swap_data", b_tdata, 32'h1234_ABCD);
        check("t5_swap_last", b_tlast, 1);
        cyc(1, 0, 16'h0000, 16'h0000);
        check("t5_swap_drained", b_tvalid, 0);

        stall_prev = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 60; c++) begin
            b_tready = (c % 2 == 1);
            enable   = 1'b1;
            if (c < 10) begin
                valid_in = 1'b1;
                i_in     = 16'h2000 + 16'(c);
                q_in     = 16'h3000 + 16'(c);
                exp_q.push_back({16'h2000 + 16'(c), 16'h3000 + 16'(c)});
            end else begin
                valid_in = 1'b0;
            end
            #3;
            if (stall_prev) begin
                check("t5_stall_tvalid", b_tvalid, 1);
                check("t5_stall_tdata", b_tdata, prev_data);
            end
            if (b_tvalid && b_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL t5_extra_beat: got 0x%0h expected no beat", b_tdata);
                end else begin
                    check("t5_beat_data", b_tdata, exp_q.pop_front());
                    check("t5_beat_last", b_tlast, 1);
                end
            end
            stall_prev = b_tvalid && !b_tready;
            prev_data  = b_tdata;
            @(posedge clk);
            #1;
            if (c >= 10 && exp_q.size() == 0) break;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL t5_timeout: got %0d beats outstanding expected 0", exp_q.size());
        end
        check("t5_end_tvalid", b_tvalid, 0);
        check("t5_end_fill", b_fill, 0);
        check("t5_end_ovf", b_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
